// File: rtl/vector_regfile_credit_if.sv
// Lane VRF port bundle: bank requests from the operand requester,
// FIFO heads toward the operand queues, and read strobes toward the LUT unit.
interface vector_regfile_credit_if #(
   parameter int unsigned NrBanks    = 8,
   parameter int unsigned VRFSize    = 65536,
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned NrOpQueues = 9,
   parameter int unsigned AddrWidth  = $clog2(VRFSize/NrBanks/DataWidth),
   parameter int unsigned QIdxWidth  = $clog2(NrOpQueues)
);
   logic [NrBanks-1:0]              req_i;
   logic [NrBanks-1:0]              gnt_o;
   logic [NrBanks-1:0]              wen_i;
   logic [NrBanks*AddrWidth-1:0]    addr_i;
   logic [NrBanks*DataWidth-1:0]    wdata_i;
   logic [NrBanks*DataWidth/8-1:0]  be_i;
   logic [NrBanks*QIdxWidth-1:0]    tgt_opqueue_i;
   logic [NrBanks-1:0]              lut_i;
   logic [NrOpQueues*DataWidth-1:0] operand_o;
   logic [NrOpQueues-1:0]           operand_valid_o;
   logic [NrOpQueues-1:0]           operand_ready_i;
   logic [NrBanks*DataWidth-1:0]    operand_lut_o;
   logic [NrBanks-1:0]              operand_lut_valid_o;

   modport master (
      output req_i, wen_i, addr_i, wdata_i, be_i,
      output tgt_opqueue_i, lut_i, operand_ready_i,
      input  gnt_o, operand_o, operand_valid_o,
      input  operand_lut_o, operand_lut_valid_o
   );

   modport slave (
      input  req_i, wen_i, addr_i, wdata_i, be_i,
      input  tgt_opqueue_i, lut_i, operand_ready_i,
      output gnt_o, operand_o, operand_valid_o,
      output operand_lut_o, operand_lut_valid_o
   );
endinterface

// File: rtl/vector_regfile_credit.sv
// Banked lane VRF with credit-gated grants, read pipeline and operand FIFOs.
// Optional VRF_CLOCK_GATE_EN: per-bank SRAM clock gating via tc_clk_gating.
module vector_regfile_credit #(
   parameter int unsigned NrBanks    = 8,
   parameter int unsigned VRFSize    = 65536,
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned NrOpQueues = 9,
   parameter int unsigned RdLatency  = 1,
   parameter int unsigned QueueDepth = 2,
   parameter int unsigned NumWords   = VRFSize/NrBanks/DataWidth,
   parameter int unsigned AddrWidth  = $clog2(NumWords),
   parameter int unsigned QIdxWidth  = $clog2(NrOpQueues)
) (
   input logic clk_i,
   input logic rst_ni,
   input logic flush_i,
   vector_regfile_credit_if.slave bus
);
   localparam int unsigned NrBytes = DataWidth/8;
   localparam int unsigned CntW = $clog2(QueueDepth+1);
   localparam int unsigned PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;

   typedef logic [DataWidth-1:0] data_t;
   typedef logic [QIdxWidth-1:0] qidx_t;
   typedef logic [CntW-1:0]      cnt_t;
   typedef logic [PtrW-1:0]      ptr_t;

   function automatic ptr_t nxt(input ptr_t p);
      return (p == ptr_t'(QueueDepth-1)) ? '0 : p + 1'b1;
   endfunction

   data_t                  wdata   [NrBanks];
   logic [NrBytes-1:0]     be      [NrBanks];
   logic [AddrWidth-1:0]   addr    [NrBanks];
   qidx_t                  tgt     [NrBanks];
   data_t                  rd_data [NrBanks];
   data_t                  last_d  [NrBanks];
   data_t                  lut_hold[NrBanks];
   logic [NrBanks-1:0]     qrd, blocked, room, gnt, rd_gnt, lut_v;
   logic [NrBanks-1:0]     bank_clk;
   logic [NrBanks-1:0]     pv [RdLatency];
   logic [NrBanks-1:0]     pl [RdLatency];
   qidx_t                  pt [RdLatency][NrBanks];
   cnt_t                   cnt_q [NrOpQueues];
   cnt_t                   fcnt  [NrOpQueues];
   ptr_t                   wptr  [NrOpQueues];
   ptr_t                   rptr  [NrOpQueues];
   data_t                  fmem  [NrOpQueues][QueueDepth];
   data_t                  push_d[NrOpQueues];
   logic [NrOpQueues-1:0]  qinc, push, empty, valid, pop, store, deq;

   for (genvar b = 0; b < NrBanks; b++) begin : g_unpack
      assign wdata[b] = bus.wdata_i[b*DataWidth +: DataWidth];
      assign be[b]    = bus.be_i[b*NrBytes +: NrBytes];
      assign addr[b]  = bus.addr_i[b*AddrWidth +: AddrWidth];
      assign tgt[b]   = bus.tgt_opqueue_i[b*QIdxWidth +: QIdxWidth];
   end

   assign qrd    = bus.req_i & ~bus.wen_i & ~bus.lut_i;
   assign gnt    = flush_i ? '0 :
                   bus.req_i & (bus.wen_i | bus.lut_i | (room & ~blocked));
   assign rd_gnt = gnt & ~bus.wen_i;
   assign bus.gnt_o = gnt;

   // Queue-read arbitration: lowest bank wins per target, target needs a credit
   always_comb begin
      blocked = '0;
      room    = '0;
      for (int b = 0; b < NrBanks; b++) begin
         for (int j = 0; j < b; j++)
            if (qrd[j] && tgt[j] == tgt[b]) blocked[b] = 1'b1;
         for (int q = 0; q < NrOpQueues; q++)
            if (tgt[b] == qidx_t'(q) && cnt_q[q] < cnt_t'(QueueDepth))
               room[b] = 1'b1;
      end
   end

   // Credit taken per queue this cycle (at most one bank per queue)
   always_comb begin
      qinc = '0;
      for (int b = 0; b < NrBanks; b++)
         for (int q = 0; q < NrOpQueues; q++)
            if (gnt[b] && qrd[b] && tgt[b] == qidx_t'(q)) qinc[q] = 1'b1;
   end

`ifdef VRF_CLOCK_GATE_EN
   logic [NrBanks-1:0] active_q;

   // Hold each bank clock open one cycle past its last access
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) active_q <= '0;
      else         active_q <= bus.req_i & gnt;
   end

   for (genvar b = 0; b < NrBanks; b++) begin : g_cg
      tc_clk_gating i_cg (
         .clk_i     (clk_i),
         .en_i      ((bus.req_i[b] & gnt[b]) | active_q[b]),
         .test_en_i (1'b0),
         .clk_o     (bank_clk[b])
      );
   end
`else
   assign bank_clk = {NrBanks{clk_i}};
`endif

   for (genvar b = 0; b < NrBanks; b++) begin : g_bank
      data_t mem [NumWords];
      data_t q_d;

      // Single-port bank: byte-masked write or registered read on grant
      always_ff @(posedge bank_clk[b]) begin
         if (gnt[b]) begin
            if (bus.wen_i[b]) begin
               for (int i = 0; i < NrBytes; i++)
                  if (be[b][i]) mem[addr[b]][i*8 +: 8] <= wdata[b][i*8 +: 8];
            end else begin
               q_d <= mem[addr[b]];
            end
         end
      end

      assign rd_data[b] = q_d;
   end

   // Read pipeline control: valid, target and LUT flag travel with the data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < RdLatency; s++) begin
            pv[s] <= '0;
            pl[s] <= '0;
            for (int b = 0; b < NrBanks; b++) pt[s][b] <= '0;
         end
      end else begin
         pv[0] <= flush_i ? '0 : rd_gnt;
         pl[0] <= bus.lut_i;
         for (int b = 0; b < NrBanks; b++) pt[0][b] <= tgt[b];
         for (int s = 1; s < RdLatency; s++) begin
            pv[s] <= flush_i ? '0 : pv[s-1];
            pl[s] <= pl[s-1];
            for (int b = 0; b < NrBanks; b++) pt[s][b] <= pt[s-1][b];
         end
      end
   end

   if (RdLatency == 1) begin : g_l1
      assign last_d = rd_data;
   end else begin : g_ln
      data_t pd [RdLatency-1][NrBanks];

      // Extra data stages, loaded only when the stage below holds a read
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int s = 0; s < RdLatency-1; s++)
               for (int b = 0; b < NrBanks; b++) pd[s][b] <= '0;
         end else begin
            for (int b = 0; b < NrBanks; b++)
               if (pv[0][b]) pd[0][b] <= rd_data[b];
            for (int s = 1; s < RdLatency-1; s++)
               for (int b = 0; b < NrBanks; b++)
                  if (pv[s][b]) pd[s][b] <= pd[s-1][b];
         end
      end

      assign last_d = pd[RdLatency-2];
   end

   assign lut_v = pv[RdLatency-1] & pl[RdLatency-1];
   assign bus.operand_lut_valid_o = lut_v;

   // LUT port keeps the last delivered word between strobes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NrBanks; b++) lut_hold[b] <= '0;
      end else begin
         for (int b = 0; b < NrBanks; b++)
            if (lut_v[b]) lut_hold[b] <= last_d[b];
      end
   end

   for (genvar b = 0; b < NrBanks; b++) begin : g_lut
      assign bus.operand_lut_o[b*DataWidth +: DataWidth] =
         lut_v[b] ? last_d[b] : lut_hold[b];
   end

   // Route pipeline exits to their queue's single push port
   always_comb begin
      push = '0;
      for (int q = 0; q < NrOpQueues; q++) begin
         push_d[q] = '0;
         for (int b = 0; b < NrBanks; b++)
            if (pv[RdLatency-1][b] && !pl[RdLatency-1][b] &&
                pt[RdLatency-1][b] == qidx_t'(q)) begin
               push[q]   = 1'b1;
               push_d[q] = push_d[q] | last_d[b];
            end
      end
   end

   for (genvar q = 0; q < NrOpQueues; q++) begin : g_q
      assign empty[q] = (fcnt[q] == '0);
      assign valid[q] = !empty[q] || push[q];
      assign pop[q]   = valid[q] && bus.operand_ready_i[q];
      assign store[q] = push[q] && !(empty[q] && pop[q]);
      assign deq[q]   = pop[q] && !empty[q];
      assign bus.operand_o[q*DataWidth +: DataWidth] =
         empty[q] ? push_d[q] : fmem[q][rptr[q]];
   end

   assign bus.operand_valid_o = valid;

   // Fall-through FIFOs and per-queue credit counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int q = 0; q < NrOpQueues; q++) begin
            cnt_q[q] <= '0;
            fcnt[q]  <= '0;
            wptr[q]  <= '0;
            rptr[q]  <= '0;
            for (int e = 0; e < QueueDepth; e++) fmem[q][e] <= '0;
         end
      end else begin
         for (int q = 0; q < NrOpQueues; q++) begin
            if (flush_i) begin
               cnt_q[q] <= '0;
               fcnt[q]  <= '0;
               wptr[q]  <= '0;
               rptr[q]  <= '0;
            end else begin
               if (store[q]) begin
                  fmem[q][wptr[q]] <= push_d[q];
                  wptr[q] <= nxt(wptr[q]);
               end
               if (deq[q]) rptr[q] <= nxt(rptr[q]);
               fcnt[q]  <= fcnt[q] + cnt_t'(store[q]) - cnt_t'(deq[q]);
               cnt_q[q] <= cnt_q[q] + cnt_t'(qinc[q]) - cnt_t'(pop[q]);
            end
         end
      end
   end
endmodule

// File: tb/tb_vector_regfile_credit.sv
// Directed bench for vector_regfile_credit (RdLatency=2, QueueDepth=2).
// Table of write/partial-write/readback vectors plus corner-case sequences.
module tb_vector_regfile_credit;
   localparam int NB = 8;
   localparam int DW = 64;
   localparam int NQ = 9;
   localparam int AW = 7;
   localparam int QW = 4;

   typedef struct {
      int          bank;
      int          addr;
      int          q;
      logic [63:0] init;
      logic [63:0] wd;
      logic [7:0]  be;
      logic [63:0] exp;
   } vec_t;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic flush_i = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   vec_t tbl [6];

   always #5 clk_i = ~clk_i;

   vector_regfile_credit_if #(
      .NrBanks(NB), .VRFSize(65536), .DataWidth(DW), .NrOpQueues(NQ)
   ) bus ();

   vector_regfile_credit #(
      .NrBanks(NB), .VRFSize(65536), .DataWidth(DW), .NrOpQueues(NQ),
      .RdLatency(2), .QueueDepth(2)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .bus     (bus.slave)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic clr();
      bus.req_i = '0;
      bus.wen_i = '0;
      bus.lut_i = '0;
      bus.addr_i = '0;
      bus.wdata_i = '0;
      bus.be_i = '0;
      bus.tgt_opqueue_i = '0;
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic op(input int b, input bit w, input bit l, input int q,
                     input int a, input logic [63:0] d,
                     input logic [7:0] m);
      bus.req_i[b] = 1'b1;
      bus.wen_i[b] = w;
      bus.lut_i[b] = l;
      bus.tgt_opqueue_i[b*QW +: QW] = QW'(q);
      bus.addr_i[b*AW +: AW] = AW'(a);
      bus.wdata_i[b*DW +: DW] = d;
      bus.be_i[b*8 +: 8] = m;
   endtask

   function automatic logic [63:0] qd(input int q);
      return bus.operand_o[q*DW +: DW];
   endfunction

   function automatic logic [63:0] ld(input int b);
      return bus.operand_lut_o[b*DW +: DW];
   endfunction

   function automatic logic [63:0] qv(input int q);
      return 64'(bus.operand_valid_o[q]);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] bm;

      tbl[0] = '{0,   5, 3, 64'h0,
                 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'hDEAD_BEEF_0123_4567};
      tbl[1] = '{3,   0, 0, 64'h0,
                 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0000_0000_FFFF_FFFF};
      tbl[2] = '{7, 127, 8, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h0, 8'hF0, 64'h0000_0000_FFFF_FFFF};
      tbl[3] = '{2,  64, 4, 64'h1111_2222_3333_4444,
                 64'hAAAA_BBBB_CCCC_DDDD, 8'h81, 64'hAA11_2222_3333_44DD};
      tbl[4] = '{5,   1, 6, 64'h0,
                 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0};
      tbl[5] = '{6,  10, 1, 64'h0,
                 64'hCAFE_F00D_1234_5678, 8'h3C, 64'h0000_F00D_1234_0000};

      clr();
      bus.operand_ready_i = '0;
      #1;
      chk("rst_qvalid", 64'(bus.operand_valid_o), 64'h0);
      chk("rst_lvalid", 64'(bus.operand_lut_valid_o), 64'h0);
      chk("rst_operand", 64'(|bus.operand_o), 64'h0);
      chk("rst_lut", 64'(|bus.operand_lut_o), 64'h0);
      cyc();
      cyc();
      rst_ni = 1'b1;
      cyc();

      // write, masked overwrite, read-after-write, pop
      for (int i = 0; i < 6; i++) begin
         bm = 8'(1 << tbl[i].bank);
         clr();
         op(tbl[i].bank, 1, 0, 0, tbl[i].addr, tbl[i].init, 8'hFF);
         #1 chk("wr_init_gnt", 64'(bus.gnt_o), 64'(bm));
         cyc();
         clr();
         op(tbl[i].bank, 1, 0, 0, tbl[i].addr, tbl[i].wd, tbl[i].be);
         #1 chk("wr_mask_gnt", 64'(bus.gnt_o), 64'(bm));
         cyc();
         clr();
         op(tbl[i].bank, 0, 0, tbl[i].q, tbl[i].addr, 64'h0, 8'h00);
         #1 chk("rd_gnt", 64'(bus.gnt_o), 64'(bm));
         cyc();
         clr();
         chk("rd_lat_early", qv(tbl[i].q), 64'h0);
         cyc();
         chk("rd_valid", qv(tbl[i].q), 64'h1);
         chk("rd_data", qd(tbl[i].q), tbl[i].exp);
         bus.operand_ready_i[tbl[i].q] = 1'b1;
         cyc();
         bus.operand_ready_i = '0;
         chk("pop_valid", qv(tbl[i].q), 64'h0);
      end

      // two banks, same target queue, same cycle
      clr();
      op(1, 1, 0, 0, 3, 64'h1111_0000_0000_0001, 8'hFF);
      op(4, 1, 0, 0, 3, 64'h4444_0000_0000_0004, 8'hFF);
      #1 chk("cf_wr_gnt", 64'(bus.gnt_o), 64'h12);
      cyc();
      clr();
      op(1, 0, 0, 2, 3, 64'h0, 8'h00);
      op(4, 0, 0, 2, 3, 64'h0, 8'h00);
      #1 chk("cf_rd_gnt", 64'(bus.gnt_o), 64'h02);
      cyc();
      clr();
      op(4, 0, 0, 2, 3, 64'h0, 8'h00);
      #1 chk("cf_retry_gnt", 64'(bus.gnt_o), 64'h10);
      cyc();
      clr();
      chk("cf_v1", qv(2), 64'h1);
      chk("cf_d1", qd(2), 64'h1111_0000_0000_0001);
      cyc();
      chk("cf_d1_hold", qd(2), 64'h1111_0000_0000_0001);
      bus.operand_ready_i[2] = 1'b1;
      cyc();
      chk("cf_v2", qv(2), 64'h1);
      chk("cf_d2", qd(2), 64'h4444_0000_0000_0004);
      cyc();
      bus.operand_ready_i = '0;
      chk("cf_empty", qv(2), 64'h0);

      // credits on queue 0 with no ready, LUT reads bypass credits
      clr();
      op(0, 0, 0, 0, 5, 64'h0, 8'h00);
      #1 chk("cr_gnt1", 64'(bus.gnt_o), 64'h01);
      cyc();
      #1 chk("cr_gnt2", 64'(bus.gnt_o), 64'h01);
      cyc();
      #1 chk("cr_gnt3_held", 64'(bus.gnt_o), 64'h00);
      chk("cr_v", qv(0), 64'h1);
      cyc();
      #1 chk("cr_gnt4_held", 64'(bus.gnt_o), 64'h00);
      cyc();
      clr();
      for (int b = 0; b < NB; b++) op(b, 0, 1, 0, 5, 64'h0, 8'h00);
      #1 chk("lut_gnt", 64'(bus.gnt_o), 64'hFF);
      cyc();
      clr();
      chk("lut_early", 64'(bus.operand_lut_valid_o), 64'h00);
      cyc();
      chk("lut_valid", 64'(bus.operand_lut_valid_o), 64'hFF);
      chk("lut_data0", ld(0), 64'hDEAD_BEEF_0123_4567);
      chk("lut_no_qv", 64'(bus.operand_valid_o), 64'h001);
      cyc();
      chk("lut_pulse_end", 64'(bus.operand_lut_valid_o), 64'h00);
      chk("lut_hold", ld(0), 64'hDEAD_BEEF_0123_4567);
      op(0, 0, 0, 0, 5, 64'h0, 8'h00);
      #1 chk("cr_gnt_full", 64'(bus.gnt_o), 64'h00);
      bus.operand_ready_i[0] = 1'b1;
      cyc();
      bus.operand_ready_i = '0;
      #1 chk("cr_gnt_after_pop", 64'(bus.gnt_o), 64'h01);
      cyc();
      clr();
      bus.operand_ready_i[0] = 1'b1;
      cyc();
      cyc();
      cyc();
      chk("cr_drained", qv(0), 64'h0);
      bus.operand_ready_i = '0;

      // flush with one FIFO entry and two reads in flight
      clr();
      op(0, 0, 0, 1, 5, 64'h0, 8'h00);
      #1 chk("fl_gnt_a", 64'(bus.gnt_o), 64'h01);
      cyc();
      clr();
      op(1, 0, 0, 4, 3, 64'h0, 8'h00);
      cyc();
      clr();
      op(2, 0, 0, 5, 64, 64'h0, 8'h00);
      cyc();
      clr();
      op(3, 0, 0, 6, 0, 64'h0, 8'h00);
      flush_i = 1'b1;
      #1 chk("fl_no_gnt", 64'(bus.gnt_o), 64'h00);
      chk("fl_setup_v", qv(1), 64'h1);
      cyc();
      flush_i = 1'b0;
      clr();
      chk("fl_qv0", 64'(bus.operand_valid_o), 64'h0);
      chk("fl_lv0", 64'(bus.operand_lut_valid_o), 64'h0);
      cyc();
      chk("fl_qv1", 64'(bus.operand_valid_o), 64'h0);
      cyc();
      chk("fl_qv2", 64'(bus.operand_valid_o), 64'h0);
      op(0, 0, 0, 1, 5, 64'h0, 8'h00);
      #1 chk("fl_fresh_gnt1", 64'(bus.gnt_o), 64'h01);
      cyc();
      #1 chk("fl_fresh_gnt2", 64'(bus.gnt_o), 64'h01);
      cyc();
      clr();
      chk("fl_fresh_v", qv(1), 64'h1);
      chk("fl_fresh_d", qd(1), 64'hDEAD_BEEF_0123_4567);
      bus.operand_ready_i[1] = 1'b1;
      cyc();
      cyc();
      cyc();
      chk("fl_drained", qv(1), 64'h0);
      bus.operand_ready_i = '0;

      // asynchronous reset while a read is in flight
      op(0, 0, 0, 7, 5, 64'h0, 8'h00);
      #1 chk("rs_gnt", 64'(bus.gnt_o), 64'h01);
      cyc();
      clr();
      chk("rs_lut_pre", ld(0), 64'hDEAD_BEEF_0123_4567);
      rst_ni = 1'b0;
      #1;
      chk("rs_lut_zero", 64'(|bus.operand_lut_o), 64'h0);
      chk("rs_qv_zero", 64'(bus.operand_valid_o), 64'h0);
      chk("rs_lv_zero", 64'(bus.operand_lut_valid_o), 64'h0);
      chk("rs_op_zero", 64'(|bus.operand_o), 64'h0);
      cyc();
      rst_ni = 1'b1;
      cyc();
      chk("rs_no_stale0", 64'(bus.operand_valid_o), 64'h0);
      cyc();
      chk("rs_no_stale1", 64'(bus.operand_valid_o), 64'h0);
      op(0, 0, 0, 7, 5, 64'h0, 8'h00);
      #1 chk("rs_fresh_gnt", 64'(bus.gnt_o), 64'h01);
      cyc();
      clr();
      cyc();
      chk("rs_fresh_v", qv(7), 64'h1);
      bus.operand_ready_i[7] = 1'b1;
      cyc();
      bus.operand_ready_i = '0;
      chk("rs_fresh_pop", qv(7), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
